// File: rtl/axis_tx_arb_pkg.sv
// Shared types and helpers for the AXI-Stream transmit arbiter.
package axis_tx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int unsigned DEF_NUM_SRC    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ID_WIDTH   = 2;

  // Bits needed to index n items, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/axis_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, modulo NUM_SRC.
module rr_arbiter
  import axis_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC  = DEF_NUM_SRC,
  parameter int unsigned ID_WIDTH = DEF_ID_WIDTH
) (
  input  logic [NUM_SRC-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [ID_WIDTH-1:0] grant,
  output logic                any_req
);

  localparam int unsigned N2    = 2 * NUM_SRC;
  localparam int unsigned IDX_W = clog2_min1(NUM_SRC);

  logic [N2-1:0]    mask;
  logic [N2-1:0]    masked;
  logic [IDX_W-1:0] idx;
  logic             found;
  int unsigned      lg;

  // Unrolling req twice lets one lowest-bit scan cover the wrap-around.
  always_comb begin
    lg    = 32'(last_grant);
    mask  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N2; i++) begin
      mask[i] = (i > lg) && (i <= lg + NUM_SRC);
    end
    masked = {req, req} & mask;
    for (int unsigned i = 0; i < N2; i++) begin
      if (!found && masked[i]) begin
        idx   = IDX_W'(i % NUM_SRC);
        found = 1'b1;
      end
    end
    grant   = ID_WIDTH'(idx);
    any_req = |req;
  end

endmodule

// File: rtl/axis_tx_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter; grant held until the TLAST beat.
// Optional per-source packet counters: define AXIS_TX_ARB_PKTCNT_EN.
module axis_tx_arbiter
  import axis_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC    = DEF_NUM_SRC,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_SRC*DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_SRC-1:0]              s_tvalid,
  input  logic [NUM_SRC-1:0]              s_tlast,
  output logic [NUM_SRC-1:0]              s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic [DATA_WIDTH/8-1:0]         m_tkeep,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  output logic [ID_WIDTH-1:0]             m_tid,
  input  logic                            m_tready,
`ifdef AXIS_TX_ARB_PKTCNT_EN
  output logic [NUM_SRC*16-1:0]           pkt_cnt,
`endif
  output logic                            busy,
  output logic [ID_WIDTH-1:0]             grant_idx
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [ID_WIDTH-1:0] arb_grant;
  logic                arb_any;
  logic                pkt_done;

  rr_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .req        (s_tvalid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  // Output mux is live only in XFER, so arbitration never accepts a beat.
  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tid    = '0;
    s_tready = '0;
    if (state_q == XFER) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (grant_idx_q == ID_WIDTH'(i)) begin
          m_tdata     = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          m_tkeep     = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
          m_tvalid    = s_tvalid[i];
          m_tlast     = s_tlast[i];
          s_tready[i] = m_tready;
        end
      end
      m_tid = grant_idx_q;
    end
  end

  assign pkt_done = m_tvalid & m_tready & m_tlast;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_idx_d  = grant_idx_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_idx_d = arb_grant;
          state_d     = XFER;
        end
      end
      XFER: begin
        if (pkt_done) begin
          last_grant_d = grant_idx_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      last_grant_q <= ID_WIDTH'(NUM_SRC - 1);
      grant_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_idx_q  <= grant_idx_d;
    end
  end

  assign busy      = (state_q == XFER);
  assign grant_idx = grant_idx_q;

`ifdef AXIS_TX_ARB_PKTCNT_EN
  logic [NUM_SRC-1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pkt_done && (grant_idx_q == ID_WIDTH'(i))) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule
